// File: rtl/dmem_responder.sv
// Data-memory slave for the RV32I core: byte-lane load/store into a word RAM
// plus a small MMIO window (LED, cycle counter, sticky fault status/address).
module dmem_responder #(
   parameter int WORD_AW = 10,
   parameter int LED_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      addr,
   input  logic [31:0]      datain,
   input  logic             we,
   input  logic [2:0]       memop,
   output logic [31:0]      dataout,
   output logic [LED_W-1:0] led,
   output logic             fault
);

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   localparam logic [1:0] REG_LED    = 2'd0;
   localparam logic [1:0] REG_CYCLE  = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_FADDR  = 2'd3;

   logic [31:0]        mem [1 << WORD_AW];
   logic [WORD_AW-1:0] wordIdx;
   logic [31:0]        ramWord;

   logic [31:0] cycleCount;
   logic [31:0] faultAddr;

   logic        isMmio;
   logic        mmioHit;
   logic        opLegal;
   logic        misaligned;
   logic        accessFault;
   logic        storeOk;
   logic        ramStore;
   logic        ledWrite;
   logic        statusClear;
   logic [3:0]  byteEn;
   logic [31:0] wrData;
   logic [7:0]  laneByte;
   logic [15:0] laneHalf;
   logic [31:0] ramLoad;
   logic [31:0] ledExt;
   logic [31:0] mmioRead;
   logic [31:0] loadData;

   assign wordIdx = addr[WORD_AW+1:2];
   assign ramWord = mem[wordIdx];

   // Access decode: every cycle is treated as an access, so legality and
   // alignment are judged on addr/memop/we regardless of direction.
   always_comb begin
      isMmio     = addr[31];
      mmioHit    = (addr[30:4] == 27'd0);
      opLegal    = 1'b0;
      misaligned = 1'b0;
      if (we) begin
         opLegal = (memop == OP_B) || (memop == OP_H) || (memop == OP_W);
      end else begin
         opLegal = (memop == OP_B) || (memop == OP_H) || (memop == OP_W) ||
                   (memop == OP_BU) || (memop == OP_HU);
      end
      if ((memop == OP_H) || (memop == OP_HU)) begin
         misaligned = addr[0];
      end else if (memop == OP_W) begin
         misaligned = (addr[1:0] != 2'b00);
      end
      accessFault = !opLegal || misaligned ||
                    (isMmio && ((memop != OP_W) || !mmioHit));
      storeOk     = we && !accessFault;
      ramStore    = storeOk && !isMmio;
      ledWrite    = storeOk && isMmio && (addr[3:2] == REG_LED);
      statusClear = storeOk && isMmio && (addr[3:2] == REG_STATUS) && datain[0];
   end

   // Store lane enables and replicated write data.
   always_comb begin
      byteEn = 4'b0000;
      wrData = datain;
      case (memop[1:0])
         2'b00: begin
            byteEn = 4'b0001 << addr[1:0];
            wrData = {4{datain[7:0]}};
         end
         2'b01: begin
            byteEn = addr[1] ? 4'b1100 : 4'b0011;
            wrData = {2{datain[15:0]}};
         end
         2'b10:   byteEn = 4'b1111;
         default: byteEn = 4'b0000;
      endcase
   end

   // Load path: lane extraction with sign/zero extension, MMIO read mux.
   always_comb begin
      laneByte = 8'h00;
      case (addr[1:0])
         2'd0: laneByte = ramWord[7:0];
         2'd1: laneByte = ramWord[15:8];
         2'd2: laneByte = ramWord[23:16];
         2'd3: laneByte = ramWord[31:24];
         default: laneByte = 8'h00;
      endcase
      laneHalf = addr[1] ? ramWord[31:16] : ramWord[15:0];
      case (memop)
         OP_B:    ramLoad = {{24{laneByte[7]}}, laneByte};
         OP_BU:   ramLoad = {24'd0, laneByte};
         OP_H:    ramLoad = {{16{laneHalf[15]}}, laneHalf};
         OP_HU:   ramLoad = {16'd0, laneHalf};
         OP_W:    ramLoad = ramWord;
         default: ramLoad = 32'd0;
      endcase
      ledExt             = 32'd0;
      ledExt[LED_W-1:0]  = led;
      case (addr[3:2])
         REG_LED:    mmioRead = ledExt;
         REG_CYCLE:  mmioRead = cycleCount;
         REG_STATUS: mmioRead = {31'd0, fault};
         REG_FADDR:  mmioRead = faultAddr;
         default:    mmioRead = 32'd0;
      endcase
      if (accessFault) begin
         loadData = 32'd0;
      end else if (isMmio) begin
         loadData = mmioRead;
      end else begin
         loadData = ramLoad;
      end
   end

   // RAM commits on the falling edge so a load in the next cycle sees it.
   always_ff @(negedge clock) begin
      if (!reset && ramStore) begin
         for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) begin
               mem[wordIdx][i*8 +: 8] <= wrData[i*8 +: 8];
            end
         end
      end
   end

   // Read capture and MMIO state; a new fault wins over a STATUS clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         dataout    <= 32'd0;
         led        <= '0;
         cycleCount <= 32'd0;
         fault      <= 1'b0;
         faultAddr  <= 32'd0;
      end else begin
         dataout    <= loadData;
         cycleCount <= cycleCount + 32'd1;
         if (ledWrite) begin
            led <= datain[LED_W-1:0];
         end
         if (accessFault) begin
            fault <= 1'b1;
         end else if (statusClear) begin
            fault <= 1'b0;
         end
         if (accessFault && !fault) begin
            faultAddr <= addr;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table for plain loads/stores,
// then hand-written sequences for faults, the cycle counter and reset.
module tb_dmem_responder;

   logic        clock;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] datain;
   logic        we;
   logic [2:0]  memop;
   logic [31:0] dataout;
   logic [15:0] led;
   logic        fault;

   int checkCount;
   int passCount;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  memop;
      logic [31:0] addr;
      logic [31:0] datain;
      logic        chkData;
      logic [31:0] expData;
      logic        expFault;
      logic [15:0] expLed;
   } vec_t;

   vec_t vecs[$];

   dmem_responder #(.WORD_AW(10), .LED_W(16)) dut (
      .clock   (clock),
      .reset   (reset),
      .addr    (addr),
      .datain  (datain),
      .we      (we),
      .memop   (memop),
      .dataout (dataout),
      .led     (led),
      .fault   (fault)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic rst, input logic w, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] d);
      reset  = rst;
      we     = w;
      memop  = op;
      addr   = a;
      datain = d;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic addVec(input string n, input logic w, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic chk,
                         input logic [31:0] ed, input logic ef, input logic [15:0] el);
      vec_t v;
      v.name = n; v.we = w; v.memop = op; v.addr = a; v.datain = d;
      v.chkData = chk; v.expData = ed; v.expFault = ef; v.expLed = el;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] cycleA;
      logic [31:0] cycleB;
      checkCount = 0;
      passCount  = 0;

      addVec("sw_10",       1, 3'b010, 32'h10,       32'h8765_4321, 0, 32'h0,          0, 16'h0);
      addVec("sw_20",       1, 3'b010, 32'h20,       32'h55AA_55AA, 0, 32'h0,          0, 16'h0);
      addVec("lw_10",       0, 3'b010, 32'h10,       32'h0,         1, 32'h8765_4321,  0, 16'h0);
      addVec("lb_13",       0, 3'b000, 32'h13,       32'h0,         1, 32'hFFFF_FF87,  0, 16'h0);
      addVec("lbu_13",      0, 3'b100, 32'h13,       32'h0,         1, 32'h0000_0087,  0, 16'h0);
      addVec("lh_12",       0, 3'b001, 32'h12,       32'h0,         1, 32'hFFFF_8765,  0, 16'h0);
      addVec("lhu_10",      0, 3'b101, 32'h10,       32'h0,         1, 32'h0000_4321,  0, 16'h0);
      addVec("lb_20",       0, 3'b000, 32'h20,       32'h0,         1, 32'hFFFF_FFAA,  0, 16'h0);
      addVec("lhu_22",      0, 3'b101, 32'h22,       32'h0,         1, 32'h0000_55AA,  0, 16'h0);
      addVec("sb_11",       1, 3'b000, 32'h11,       32'h1234_56AA, 0, 32'h0,          0, 16'h0);
      addVec("lw_after_sb", 0, 3'b010, 32'h10,       32'h0,         1, 32'h8765_AA21,  0, 16'h0);
      addVec("sh_12",       1, 3'b001, 32'h12,       32'hFFFF_BEEF, 0, 32'h0,          0, 16'h0);
      addVec("lw_after_sh", 0, 3'b010, 32'h10,       32'h0,         1, 32'hBEEF_AA21,  0, 16'h0);
      addVec("sw_alias",    1, 3'b010, 32'h1000,     32'h1234_5678, 0, 32'h0,          0, 16'h0);
      addVec("lw_alias",    0, 3'b010, 32'h0,        32'h0,         1, 32'h1234_5678,  0, 16'h0);
      addVec("sw_led",      1, 3'b010, 32'h8000_0000, 32'hFFFF_ABCD, 0, 32'h0,         0, 16'hABCD);
      addVec("lw_led",      0, 3'b010, 32'h8000_0000, 32'h0,        1, 32'h0000_ABCD,  0, 16'hABCD);
      addVec("lw_status",   0, 3'b010, 32'h8000_0008, 32'h0,        1, 32'h0,          0, 16'hABCD);
      addVec("lw_faddr",    0, 3'b010, 32'h8000_000C, 32'h0,        1, 32'h0,          0, 16'hABCD);

      reset = 1'b1; we = 1'b0; memop = 3'b010; addr = 32'h0; datain = 32'h0;
      @(posedge clock);
      applyStimulus(1, 0, 3'b010, 32'h0, 32'h0);
      checkOutput("reset_dataout", dataout, 32'h0);
      checkOutput("reset_led", {16'h0, led}, 32'h0);
      checkOutput("reset_fault", {31'h0, fault}, 32'h0);

      foreach (vecs[i]) begin
         applyStimulus(0, vecs[i].we, vecs[i].memop, vecs[i].addr, vecs[i].datain);
         if (vecs[i].chkData) checkOutput({vecs[i].name, "_data"}, dataout, vecs[i].expData);
         checkOutput({vecs[i].name, "_fault"}, {31'h0, fault}, {31'h0, vecs[i].expFault});
         checkOutput({vecs[i].name, "_led"}, {16'h0, led}, {16'h0, vecs[i].expLed});
      end

      // Misaligned load latches the fault and its address.
      applyStimulus(0, 0, 3'b010, 32'h12, 32'h0);
      checkOutput("mis_lw_data", dataout, 32'h0);
      checkOutput("mis_lw_fault", {31'h0, fault}, 32'h1);
      applyStimulus(0, 0, 3'b010, 32'h8000_000C, 32'h0);
      checkOutput("faddr_12", dataout, 32'h12);
      applyStimulus(0, 0, 3'b010, 32'h8000_0008, 32'h0);
      checkOutput("status_set", dataout, 32'h1);

      // Misaligned store is dropped and does not move fault_addr.
      applyStimulus(0, 1, 3'b010, 32'h21, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 3'b010, 32'h20, 32'h0);
      checkOutput("mis_sw_ram", dataout, 32'h55AA_55AA);
      applyStimulus(0, 0, 3'b010, 32'h8000_000C, 32'h0);
      checkOutput("faddr_kept", dataout, 32'h12);
      applyStimulus(0, 1, 3'b010, 32'h8000_0008, 32'h1);
      checkOutput("status_clear", {31'h0, fault}, 32'h0);

      // Reserved memop, clear with bit0=0, unmapped MMIO, sub-word MMIO.
      applyStimulus(0, 0, 3'b011, 32'h44, 32'h0);
      checkOutput("rsv_load_data", dataout, 32'h0);
      checkOutput("rsv_load_fault", {31'h0, fault}, 32'h1);
      applyStimulus(0, 1, 3'b010, 32'h8000_0008, 32'hFFFF_FFFE);
      checkOutput("clear_bit0_zero", {31'h0, fault}, 32'h1);
      applyStimulus(0, 0, 3'b010, 32'h8000_0010, 32'h0);
      checkOutput("unmapped_data", dataout, 32'h0);
      applyStimulus(0, 1, 3'b100, 32'h20, 32'h0);
      applyStimulus(0, 0, 3'b000, 32'h8000_0000, 32'h0);
      checkOutput("mmio_lb_data", dataout, 32'h0);
      applyStimulus(0, 0, 3'b010, 32'h8000_000C, 32'h0);
      checkOutput("faddr_first", dataout, 32'h44);
      applyStimulus(0, 1, 3'b010, 32'h8000_0008, 32'hFFFF_FFFF);
      checkOutput("status_clear2", {31'h0, fault}, 32'h0);
      applyStimulus(0, 0, 3'b010, 32'h20, 32'h0);
      checkOutput("rsv_store_ram", dataout, 32'h55AA_55AA);

      // Cycle counter: reads five posedges apart differ by five.
      applyStimulus(0, 0, 3'b010, 32'h8000_0004, 32'h0);
      cycleA = dataout;
      applyStimulus(0, 1, 3'b010, 32'h8000_0004, 32'h0);
      checkOutput("cycle_wr_nofault", {31'h0, fault}, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3'b010, 32'h0, 32'h0);
      applyStimulus(0, 0, 3'b010, 32'h8000_0004, 32'h0);
      cycleB = dataout;
      checkOutput("cycle_delta", cycleB - cycleA, 32'd5);

      // Reset mid-run with a store pending must not touch RAM.
      applyStimulus(0, 1, 3'b010, 32'h40, 32'h1111_2222);
      applyStimulus(0, 0, 3'b010, 32'h41, 32'h0);
      checkOutput("pre_reset_fault", {31'h0, fault}, 32'h1);
      applyStimulus(1, 1, 3'b010, 32'h40, 32'hFFFF_FFFF);
      checkOutput("mid_reset_dataout", dataout, 32'h0);
      checkOutput("mid_reset_led", {16'h0, led}, 32'h0);
      checkOutput("mid_reset_fault", {31'h0, fault}, 32'h0);
      applyStimulus(0, 0, 3'b010, 32'h8000_0004, 32'h0);
      checkOutput("cycle_after_reset", dataout, 32'h0);
      applyStimulus(0, 0, 3'b010, 32'h40, 32'h0);
      checkOutput("ram_kept_in_reset", dataout, 32'h1111_2222);
      applyStimulus(0, 0, 3'b010, 32'h8000_000C, 32'h0);
      checkOutput("faddr_after_reset", dataout, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
